// File: rtl/db_timer_arbiter.sv
// Round-robin arbiter sharing one prescaled debounce interval timer among N debouncers.
// Optional build macro DBT_RESTART_EN: a repeat request from the served channel restarts its interval.
module db_timer_arbiter #(
  parameter int N        = 4,
  parameter int TICKS    = 16,
  parameter int PRESCALE = 1000,
  localparam int CW  = (TICKS > 1) ? $clog2(TICKS) : 1,
  localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1,
  localparam int CHW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   strt,
  output logic [N-1:0]   cnt,
  output logic           busy,
  output logic [CHW-1:0] act_ch,
  output logic [N-1:0]   pend
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PW-1:0]  PSC_MAX  = PW'(PRESCALE - 1);
  localparam logic [CW-1:0]  TICK_MAX = CW'(TICKS - 1);
  localparam logic [CHW-1:0] LAST_CH  = CHW'(N - 1);

  state_t         state_reg;
  logic [N-1:0]   pend_reg;
  logic [N-1:0]   pend_next;
  logic [N-1:0]   cnt_reg;
  logic           busy_reg;
  logic [CHW-1:0] act_ch_reg;
  logic [CHW-1:0] rr_ptr_reg;
  logic [PW-1:0]  psc_reg;
  logic [CW-1:0]  tick_reg;

  logic [N-1:0]   act_dec;
  logic [CHW-1:0] winner;
  logic           found;
  logic           restart;
  int             idx;

  // Set wins over the DONE-edge clear, so a request in the DONE cycle re-queues.
  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign act_dec[gi]   = (act_ch_reg == CHW'(gi));
    assign pend_next[gi] = strt[gi] | (pend_reg[gi] & ~((state_reg == DONE) & act_dec[gi]));
  end

`ifdef DBT_RESTART_EN
  assign restart = strt[act_ch_reg];
`else
  assign restart = 1'b0;
`endif

  // First pending channel at or after rr_ptr, wrapping through N-1 to 0.
  always_comb begin
    winner = rr_ptr_reg;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= N) idx = idx - N;
      if (!found && pend_reg[idx]) begin
        found  = 1'b1;
        winner = CHW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      pend_reg   <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      act_ch_reg <= '0;
      rr_ptr_reg <= '0;
      psc_reg    <= '0;
      tick_reg   <= '0;
    end else begin
      pend_reg <= pend_next;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (found) begin
            act_ch_reg <= winner;
            rr_ptr_reg <= (winner == LAST_CH) ? '0 : winner + 1'b1;
            psc_reg    <= '0;
            tick_reg   <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          if (restart) begin
            psc_reg  <= '0;
            tick_reg <= '0;
          end else if (psc_reg == PSC_MAX) begin
            psc_reg <= '0;
            if (tick_reg == TICK_MAX) begin
              cnt_reg   <= act_dec;
              state_reg <= DONE;
            end else begin
              tick_reg <= tick_reg + 1'b1;
            end
          end else begin
            psc_reg <= psc_reg + 1'b1;
          end
        end
        DONE: begin
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign cnt    = cnt_reg;
  assign busy   = busy_reg;
  assign act_ch = act_ch_reg;
  assign pend   = pend_reg;

endmodule

// File: tb/tb_db_timer_arbiter.sv
// Directed bench for db_timer_arbiter with N=4, TICKS=4, PRESCALE=2 (interval = 8 cycles).
module tb_db_timer_arbiter;

  localparam int N = 4;

`ifdef DBT_RESTART_EN
  localparam int RESTART_DONE = 15;
`else
  localparam int RESTART_DONE = 10;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] strt = '0;
  logic [N-1:0] cnt;
  logic         busy;
  logic [1:0]   act_ch;
  logic [N-1:0] pend;

  int checks = 0;
  int errors = 0;

  db_timer_arbiter #(.N(N), .TICKS(4), .PRESCALE(2)) dut (
    .clk(clk), .rst_n(rst_n), .strt(strt), .cnt(cnt),
    .busy(busy), .act_ch(act_ch), .pend(pend)
  );

  always #5 clk = ~clk;

  // Cycle c spans posedge c to posedge c+1; inputs and checks happen 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    strt  = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    strt  = 4'b1111;
    step();
    step();
    checks++;
    if (pend !== 4'b0000) begin errors++; $display("FAIL reset_pend got=%b exp=0000", pend); end
    checks++;
    if (cnt !== 4'b0000) begin errors++; $display("FAIL reset_cnt got=%b exp=0000", cnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (act_ch !== 2'd0) begin errors++; $display("FAIL reset_act_ch got=%0d exp=0", act_ch); end
    strt = '0;
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || pend !== 4'b0000) begin
      errors++; $display("FAIL reset_release busy=%b pend=%b exp busy=0 pend=0000", busy, pend);
    end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    logic [N-1:0] exp_cnt;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      strt = (c == 0) ? 4'b0100 : 4'b0000;
      exp_cnt = (c == 10) ? 4'b0100 : 4'b0000;
      checks++;
      if (busy !== (c >= 2 && c <= 10)) begin
        errors++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy, (c >= 2 && c <= 10));
      end
      checks++;
      if (cnt !== exp_cnt) begin errors++; $display("FAIL single_cnt c=%0d got=%b exp=%b", c, cnt, exp_cnt); end
      if (c == 1 || c == 11) begin
        checks++;
        if (pend[2] !== (c == 1)) begin
          errors++; $display("FAIL single_pend c=%0d got=%b exp=%b", c, pend[2], (c == 1));
        end
      end
      if (c == 10) begin
        checks++;
        if (act_ch !== 2'd2) begin errors++; $display("FAIL single_act_ch got=%0d exp=2", act_ch); end
      end
      step();
    end
    $display("test_single: strt[2] serviced, cnt expected at cycle 10");
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_cnt;
    do_reset();
    for (int c = 0; c <= 32; c++) begin
      strt = (c == 0) ? 4'b1011 : 4'b0000;
      case (c)
        10:      exp_cnt = 4'b0001;
        20:      exp_cnt = 4'b0010;
        30:      exp_cnt = 4'b1000;
        default: exp_cnt = 4'b0000;
      endcase
      checks++;
      if (cnt !== exp_cnt) begin errors++; $display("FAIL contention_cnt c=%0d got=%b exp=%b", c, cnt, exp_cnt); end
      if (c == 11 || c == 21) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle c=%0d busy=%b exp=0", c, busy); end
      end
      if (c == 12 || c == 22) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_run c=%0d busy=%b exp=1", c, busy); end
      end
      if (c == 20) begin
        checks++;
        if (act_ch !== 2'd1) begin errors++; $display("FAIL contention_act c=20 got=%0d exp=1", act_ch); end
      end
      step();
    end
    checks++;
    if (dut.rr_ptr_reg !== 2'd0) begin errors++; $display("FAIL contention_rr_ptr got=%0d exp=0", dut.rr_ptr_reg); end
    checks++;
    if (act_ch !== 2'd3) begin errors++; $display("FAIL contention_hold_act got=%0d exp=3", act_ch); end
    $display("test_contention: order ch0, ch1, ch3 at cycles 10, 20, 30");
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_cnt;
    do_reset();
    for (int c = 0; c <= 31; c++) begin
      if (c == 0)                 strt = 4'b0101;
      else if (c == 10 || c == 20) strt = 4'b0001;
      else                        strt = 4'b0000;
      case (c)
        10:      exp_cnt = 4'b0001;
        20:      exp_cnt = 4'b0100;
        30:      exp_cnt = 4'b0001;
        default: exp_cnt = 4'b0000;
      endcase
      checks++;
      if (cnt !== exp_cnt) begin errors++; $display("FAIL fairness_cnt c=%0d got=%b exp=%b", c, cnt, exp_cnt); end
      if (c == 11) begin
        checks++;
        if (pend !== 4'b0101) begin errors++; $display("FAIL fairness_pend c=11 got=%b exp=0101", pend); end
      end
      step();
    end
    $display("test_fairness: order ch0, ch2, ch0");
  endtask

  task automatic test_restart();
    logic [N-1:0] exp_cnt;
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      strt = (c == 0 || c == 6) ? 4'b0010 : 4'b0000;
      exp_cnt = (c == RESTART_DONE) ? 4'b0010 : 4'b0000;
      checks++;
      if (cnt !== exp_cnt) begin errors++; $display("FAIL restart_cnt c=%0d got=%b exp=%b", c, cnt, exp_cnt); end
      step();
    end
    checks++;
    if (pend !== 4'b0000) begin errors++; $display("FAIL restart_pend got=%b exp=0000", pend); end
    $display("test_restart: cnt[1] expected at cycle %0d", RESTART_DONE);
  endtask

  task automatic test_requeue();
    logic [N-1:0] exp_cnt;
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      strt = (c == 0 || c == 10) ? 4'b0001 : 4'b0000;
      exp_cnt = (c == 10 || c == 20) ? 4'b0001 : 4'b0000;
      checks++;
      if (cnt !== exp_cnt) begin errors++; $display("FAIL requeue_cnt c=%0d got=%b exp=%b", c, cnt, exp_cnt); end
      if (c == 11 || c == 21) begin
        checks++;
        if (pend[0] !== (c == 11)) begin
          errors++; $display("FAIL requeue_pend c=%0d got=%b exp=%b", c, pend[0], (c == 11));
        end
      end
      step();
    end
    $display("test_requeue: cnt[0] expected at cycles 10 and 20");
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      strt = (c == 0) ? 4'b0100 : 4'b0000;
      if (c == 5) begin
        rst_n = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got=%b exp=1", busy); end
      end
      step();
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++;
    if (pend !== 4'b0000) begin errors++; $display("FAIL midrst_pend got=%b exp=0000", pend); end
    checks++;
    if (cnt !== 4'b0000) begin errors++; $display("FAIL midrst_cnt got=%b exp=0000", cnt); end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (cnt !== 4'b0000 || busy !== 1'b0) begin
        errors++; $display("FAIL midrst_quiet c=%0d cnt=%b busy=%b exp cnt=0000 busy=0", c, cnt, busy);
      end
    end
    $display("test_reset_mid_run: interval aborted");
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_restart();
    test_requeue();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/db_timer_arbiter.md
# db_timer_arbiter

Shares one debounce interval timer among N push-button debounce state machines in the mood-lighting front end. Each debouncer pulses its `strt` request; the block queues requests, serves them round-robin on a single prescaled counter, and returns a one-cycle `cnt` pulse to the served channel when its interval expires. This replaces one full-width timer per button with a single timer.

## Interface
- `N`, 4: number of debouncer channels (2..8).
- `TICKS`, 16: interval length in prescaled ticks (≥1).
- `PRESCALE`, 1000: clk cycles per tick (≥1).
- `CW`, `$clog2(TICKS)` (min 1): tick counter width; derived, not overridden.
- `PW`, `$clog2(PRESCALE)` (min 1): prescaler width; derived, not overridden.
- `CHW`, `$clog2(N)`: channel index width; derived, not overridden.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `strt`  in  N  per-channel interval request; a one-cycle pulse from each debouncer.
- `cnt`  out  N  per-channel interval-done pulse; at most one bit set, high for one cycle.
- `busy`  out  1  high in RUN and DONE.
- `act_ch`  out  CHW  channel currently served; holds the last served value when idle.
- `pend`  out  N  pending-request flags.

## Operation
- Pending: `pend[i]` sets on any clock edge with `strt[i]`=1. It clears only at the DONE edge for channel `act_ch`. If set and clear coincide, set wins and the channel is re-queued.
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: if `pend`≠0, grant the round-robin winner: `act_ch`←winner, prescaler←0, tick counter←0, go to RUN. Otherwise stay in IDLE.
- Round-robin search starts at `rr_ptr`. On each grant, `rr_ptr`←winner+1, wrapping from N-1 to 0.
- RUN: the prescaler increments every cycle and wraps at PRESCALE-1. On each prescaler wrap, the tick counter increments. When the prescaler equals PRESCALE-1 and the tick counter equals TICKS-1, go to DONE.
- DONE: `cnt[act_ch]`=1 for this single cycle, clear `pend[act_ch]` (subject to the set-wins rule), then go to IDLE unconditionally.
- Requests from non-active channels during RUN or DONE only set `pend`. They never disturb the running interval.
- `strt` from a channel that is already pending has no extra effect. Requests do not stack.
- Reset values: state IDLE, `pend`=0, `cnt`=0, `busy`=0, `act_ch`=0, `rr_ptr`=0, prescaler=0, tick counter=0.
- Reset mid-RUN aborts the interval. No `cnt` pulse is issued and all pending requests are discarded.

## Timing
- `strt[i]` high in cycle 0, timer idle, no competing requests: `pend[i]` is high in cycle 1, RUN lasts cycles 2..1+TICKS·PRESCALE, and `cnt[i]` is high in cycle 2+TICKS·PRESCALE.
- Back-to-back service: after DONE there is one IDLE cycle. The next channel's RUN starts 2 cycles after the previous `cnt` pulse.
- Worst-case wait for any pending channel: (N-1)·(TICKS·PRESCALE+2) cycles before its own grant.
- `cnt`, `busy` and `act_ch` are decoded from registered state only. There is no combinational path from `strt` to any output.
- `busy` is high exactly from the first RUN cycle through the DONE cycle.

## Configuration
- `DBT_RESTART_EN` defined: `strt[act_ch]` during RUN clears the prescaler and tick counter at that edge. The full interval restarts and `cnt` is delayed accordingly.
- `DBT_RESTART_EN` undefined: `strt[act_ch]` during RUN is ignored. The interval completes at its original time.
- In both builds, `strt[act_ch]` in the DONE cycle re-queues the channel (set wins).

## Test plan
- Single request, with N=4, TICKS=4, PRESCALE=2: `strt[2]` in cycle 0 -> `pend[2]`=1 in cycle 1, `busy`=1 in cycles 2..10, `cnt`=4'b0100 in cycle 10 only, `pend[2]`=0 in cycle 11.
- Contention, same parameters: `strt`=4'b1011 in cycle 0 -> `cnt` pulses in order ch0 (cycle 10), ch1 (cycle 20), ch3 (cycle 30). `rr_ptr` ends at 0.
- Fairness: keep ch0 requesting in every DONE cycle while ch2 is pending -> served order alternates ch0, ch2, ch0. ch2 is never starved.
- Restart, with `strt[1]` in cycle 0 and again in cycle 6: `DBT_RESTART_EN` defined gives `cnt[1]` in cycle 15; undefined gives `cnt[1]` in cycle 10.
- Re-queue: `strt[0]` asserted in the DONE cycle of channel 0 -> `pend[0]` stays 1 and a second `cnt[0]` arrives 10 cycles after the first.
- Reset mid-RUN: `rst_n`=0 in cycle 5 of the single-request scenario -> `busy`, `pend` and `cnt` are 0 from the next edge, and no `cnt` pulse appears within 20 cycles.
